mc_sequencer: RTL and testbench

Multicycle main sequencer for the single-memory MIPS-subset datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write strobes. It stalls on a memory ready handshake and counts retired instructions. It sits beside the ALU decoder inside the controller; PCEn is formed outside as (Branch & ZeroFlag) | PCWrite.

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_outdec.sv | 77 +++++++
 rtl/mc_sequencer.sv | 125 ++++++++++++
 tb/tb_mc_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, state encodings,
// datapath select encodings and the control word. MC_BNE_EN adds the BranchNe field.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
`ifdef MC_BNE_EN
    logic       branch_ne;
`endif
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decode. Everything is forced to zero
// while reset is low so in-flight strobes drop asynchronously. Honours MC_BNE_EN.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   rst_n_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (rst_n_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_req   = 1'b1;
          ctrl_o.alu_src_b = SRCB_FOUR;
          // One IR load / PC bump per fetch, however long memory stalls.
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        S_DECODE:  ctrl_o.alu_src_b = SRCB_IMMSH;
        S_MEMADR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          ctrl_o.mem_req = 1'b1;
          ctrl_o.iord    = 1'b1;
        end
        S_MEMWB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.memto_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl_o.mem_req   = 1'b1;
          ctrl_o.iord      = 1'b1;
          ctrl_o.mem_write = 1'b1;
        end
        S_RTYPEEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_op    = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = 1'b1;
        end
        S_BEQEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_op    = ALUOP_SUB;
          ctrl_o.pc_src    = PCSRC_ALUOUT;
          ctrl_o.branch    = 1'b1;
        end
        S_ADDIEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_ADDIWB:  ctrl_o.reg_write = 1'b1;
        S_JEX: begin
          ctrl_o.pc_src   = PCSRC_JUMP;
          ctrl_o.pc_write = 1'b1;
        end
`ifdef MC_BNE_EN
        S_BNEEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_op    = ALUOP_SUB;
          ctrl_o.pc_src    = PCSRC_ALUOUT;
          ctrl_o.branch_ne = 1'b1;
        end
`endif
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle MIPS-subset main sequencer: state register, next-state logic and
// retired-instruction counter. Define MC_BNE_EN to add BNE and the BranchNe port.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic             PCWrite,
  output logic             Branch,
`ifdef MC_BNE_EN
  output logic             BranchNe,
`endif
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        // The store only commits, and retires, once memory accepts it.
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .rst_n_i     (reset),
    .ctrl_o      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.memto_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSrc      = ctrl.pc_src;
  assign ALUOp      = ctrl.alu_op;
  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
`ifdef MC_BNE_EN
  assign BranchNe   = ctrl.branch_ne;
`endif
  assign illegal_op = illegal & reset;
  assign retired    = retired_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer; expected values are hand-derived per step.
// Handles both MC_BNE_EN builds.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        mem_ready;
  logic        mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc, ALUOp;
  logic        PCWrite, Branch, illegal_op;
`ifdef MC_BNE_EN
  logic        BranchNe;
`endif
  logic [31:0] retired;
  logic [3:0]  state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUOp      (ALUOp),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
`ifdef MC_BNE_EN
    .BranchNe   (BranchNe),
`endif
    .illegal_op (illegal_op),
    .retired    (retired),
    .state_o    (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; op = 6'd0;
    tick(); tick(); tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_srcb", 32'(ALUSrcB), 32'd0);
    chk("rst_retired", retired, 32'd0);

    // ADDI: 0,1,9,10,0
    reset = 1'b1; mem_ready = 1'b1; op = 6'b001000; #1;
    chk("addi_f_state", 32'(state_o), 32'd0);
    chk("addi_f_irw", 32'(IRWrite), 32'd1);
    chk("addi_f_srcb", 32'(ALUSrcB), 32'd1);
    tick();
    chk("addi_d_state", 32'(state_o), 32'd1);
    chk("addi_d_srcb", 32'(ALUSrcB), 32'd3);
    tick();
    chk("addi_ex_state", 32'(state_o), 32'd9);
    chk("addi_ex_regw", 32'(RegWrite), 32'd0);
    chk("addi_ex_srcb", 32'(ALUSrcB), 32'd2);
    tick();
    chk("addi_wb_state", 32'(state_o), 32'd10);
    chk("addi_wb_regw", 32'(RegWrite), 32'd1);
    chk("addi_wb_dst", 32'(RegDst), 32'd0);
    tick();
    chk("addi_end_state", 32'(state_o), 32'd0);
    chk("addi_retired", retired, 32'd1);

    // LW with fetch and memory-read stalls
    op = 6'b100011; mem_ready = 1'b0; #1;
    chk("lw_f0_irw", 32'(IRWrite), 32'd0);
    chk("lw_f0_req", 32'(mem_req), 32'd1);
    tick();
    chk("lw_f1_state", 32'(state_o), 32'd0);
    chk("lw_f1_pcw", 32'(PCWrite), 32'd0);
    mem_ready = 1'b1; #1;
    chk("lw_f2_irw", 32'(IRWrite), 32'd1);
    chk("lw_f2_pcw", 32'(PCWrite), 32'd1);
    tick();
    mem_ready = 1'b0; #1;
    chk("lw_d_state", 32'(state_o), 32'd1);
    chk("lw_d_irw", 32'(IRWrite), 32'd0);
    tick();
    chk("lw_adr_state", 32'(state_o), 32'd2);
    chk("lw_adr_srca", 32'(ALUSrcA), 32'd1);
    tick();
    chk("lw_rd0_state", 32'(state_o), 32'd3);
    chk("lw_rd0_iord", 32'(IorD), 32'd1);
    tick();
    chk("lw_rd1_req", 32'(mem_req), 32'd1);
    tick();
    chk("lw_rd2_state", 32'(state_o), 32'd3);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_state", 32'(state_o), 32'd4);
    chk("lw_wb_m2r", 32'(MemtoReg), 32'd1);
    chk("lw_wb_regw", 32'(RegWrite), 32'd1);
    chk("lw_wb_retired", retired, 32'd1);
    tick();
    chk("lw_end_state", 32'(state_o), 32'd0);
    chk("lw_retired", retired, 32'd2);

    // SW with two wait cycles in MEMWR
    op = 6'b101011;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("sw_wr0_state", 32'(state_o), 32'd5);
    chk("sw_wr0_mw", 32'(MemWrite), 32'd1);
    chk("sw_wr0_iord", 32'(IorD), 32'd1);
    tick();
    chk("sw_wr1_mw", 32'(MemWrite), 32'd1);
    tick();
    mem_ready = 1'b1; #1;
    chk("sw_wr2_mw", 32'(MemWrite), 32'd1);
    chk("sw_wr2_retired", retired, 32'd2);
    tick();
    chk("sw_end_state", 32'(state_o), 32'd0);
    chk("sw_end_mw", 32'(MemWrite), 32'd0);
    chk("sw_retired", retired, 32'd3);

    // Illegal opcode
    op = 6'b111111;
    tick();
    chk("ill_d_pulse", 32'(illegal_op), 32'd1);
    tick();
    chk("ill_state", 32'(state_o), 32'd0);
    chk("ill_pulse_off", 32'(illegal_op), 32'd0);
    chk("ill_retired", retired, 32'd3);

    // BEQ then J
    op = 6'b000100;
    tick(); tick();
    chk("beq_state", 32'(state_o), 32'd8);
    chk("beq_branch", 32'(Branch), 32'd1);
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_aluop", 32'(ALUOp), 32'd1);
    tick();
    chk("beq_end_state", 32'(state_o), 32'd0);
    chk("beq_retired", retired, 32'd4);
    op = 6'b000010;
    tick(); tick();
    chk("j_state", 32'(state_o), 32'd11);
    chk("j_pcw", 32'(PCWrite), 32'd1);
    chk("j_pcsrc", 32'(PCSrc), 32'd2);
    tick();
    chk("j_end_state", 32'(state_o), 32'd0);
    chk("j_retired", retired, 32'd5);

    // R-type
    op = 6'b000000;
    tick(); tick();
    chk("r_ex_state", 32'(state_o), 32'd6);
    chk("r_ex_aluop", 32'(ALUOp), 32'd2);
    tick();
    chk("r_wb_state", 32'(state_o), 32'd7);
    chk("r_wb_dst", 32'(RegDst), 32'd1);
    chk("r_wb_regw", 32'(RegWrite), 32'd1);
    tick();
    chk("r_retired", retired, 32'd6);

    // BNE
    op = 6'b000101;
    tick();
`ifdef MC_BNE_EN
    chk("bne_d_ill", 32'(illegal_op), 32'd0);
    tick();
    chk("bne_state", 32'(state_o), 32'd12);
    chk("bne_brne", 32'(BranchNe), 32'd1);
    chk("bne_branch", 32'(Branch), 32'd0);
    tick();
    chk("bne_retired", retired, 32'd7);
`else
    chk("bne_d_ill", 32'(illegal_op), 32'd1);
    tick();
    chk("bne_state", 32'(state_o), 32'd0);
    chk("bne_retired", retired, 32'd6);
`endif

    // Reset during MEMWR
    op = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("rmw_pre_mw", 32'(MemWrite), 32'd1);
    reset = 1'b0; #1;
    chk("rmw_mw", 32'(MemWrite), 32'd0);
    chk("rmw_req", 32'(mem_req), 32'd0);
    chk("rmw_state", 32'(state_o), 32'd0);
    chk("rmw_retired", retired, 32'd0);
    tick();
    reset = 1'b1; #1;
    chk("rmw_rel_state", 32'(state_o), 32'd0);
    chk("rmw_rel_req", 32'(mem_req), 32'd1);
    tick();
    chk("rmw_hold_state", 32'(state_o), 32'd0);
    chk("rmw_rel_retired", retired, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
